anton_neopixel_stream_seq: RTL and testbench
============================================

# anton_neopixel_stream_seq

Parametrised NeoPixel stream sequencer and successor of the fixed 24-bit / 8-substep stream controller. It owns the IDLE/TRANSMIT/RESET state machine, the substep, bit and pixel counters, and the registered serial output. It sits between the register file (ctrl bits) and the pixel buffer, which it addresses directly. It supports 24-bit (GRB) and 32-bit (GRBW) pixels, configurable T0H/T1H shaping, configurable reset gap and pixel count.

## Interface
Parameters:
- PIXELS, 8: pixels per frame; ≥1.
- SUBSTEPS, 8: clk7mhz cycles per data bit; ≥2.
- T0H, 2: substeps high for a 0 bit; 1 ≤ T0H < T1H.
- T1H, 5: substeps high for a 1 bit; T1H < SUBSTEPS.
- RESET_CYCLES, 400: low cycles after the last bit (≥50 µs at 7 MHz); ≥1.

Ports:
- clk7mhz, in, 1: sole clock; all state on the rising edge.
- rstn, in, 1: reset, asynchronous assert, active-low.
- reg_ctrl_init, in, 1: synchronous abort; forces IDLE.
- reg_ctrl_run, in, 1: enable streaming.
- reg_ctrl_32bit, in, 1: 1 = 32 bits/pixel, 0 = 24.
- pixel_data, in, 32: data for pixel_addr. Must be valid combinationally while pixel_addr is stable. 24-bit mode uses [23:0].
- pixel_addr, out, $clog2(PIXELS) (min 1): registered index of the pixel being sent.
- state, out, 2: `ENUM_STATE_IDLE`=0, `ENUM_STATE_TRANSMIT`=1, `ENUM_STATE_RESET`=2.
- neo_out, out, 1: registered serial data line.
- bit_pattern_index_out, out, $clog2(SUBSTEPS): current substep.
- pixel_bit_index_out, out, 5: current bit. Counts down, MSB first.
- frame_done, out, 1: one-cycle pulse in the last RESET cycle.

## Operation
- Reset (rstn low) sets:
  - state=IDLE
  - all counters 0
  - neo_out=0, frame_done=0, pixel_addr=0
  - mode reg=0 (24-bit)
  - armed=1
- IDLE→TRANSMIT when reg_ctrl_run && !reg_ctrl_init && armed. On this transition:
  - reg_ctrl_32bit is latched into the mode reg.
  - Bit index loads 31 or 23.
  - Substep and pixel_addr load 0.
- The mode reg is held for the whole frame. reg_ctrl_32bit changes mid-frame are ignored.
- TRANSMIT, each cycle:
  - Substep increments and wraps at SUBSTEPS-1.
  - On wrap, the bit index decrements.
  - When the bit index is 0 and the substep wraps, the bit index reloads 31/23 and pixel_addr increments.
  - On the last substep of bit 0 of pixel PIXELS-1, state goes to RESET.
- neo_out next = (state==TRANSMIT) && (substep < (pixel_data[bit] ? T1H : T0H)); otherwise 0.
- RESET:
  - A counter runs 0..RESET_CYCLES-1 and neo_out stays 0.
  - frame_done pulses when the counter = RESET_CYCLES-1.
  - The next state is decided in that same cycle (see Configuration).
- reg_ctrl_run falling mid-frame does not abort. The frame completes, then the block goes to IDLE.
- reg_ctrl_init high in any state: next cycle state=IDLE, counters 0, neo_out=0, no frame_done. Init has priority over every other event.
- armed: cleared on frame end when looping is disabled; set whenever reg_ctrl_run is low.

## Timing
- neo_out lags the substep/bit counters by 1 cycle (registered).
- Frame length: PIXELS × bits × SUBSTEPS + RESET_CYCLES cycles, where bits = 24 or 32.
- Defaults: 8 × 24 × 8 + 400 = 1936 cycles.
- pixel_addr changes on the cycle after the last substep of bit 0. The pixel buffer has until the next clock edge to present the new pixel_data.
- Run-to-first-high-output latency from IDLE: 2 cycles (transition cycle, then the registered output).

## Configuration
- ANTON_NEOPIXEL_LOOP_EN defined: at RESET end, if reg_ctrl_run is still high (and not init), go straight back to TRANSMIT and re-latch the mode. There is no IDLE cycle between frames.
- ANTON_NEOPIXEL_LOOP_EN undefined: at RESET end, always go to IDLE and clear armed. The next frame needs reg_ctrl_run low for at least 1 cycle, then high again (one-shot per run assertion).

## Structure
- The state encodings `ENUM_STATE_*` and the 24/32 bit-count constants belong in the shared anton_common.vh.
- Sub-module anton_neopixel_bit_shaper: combinational compare of substep against T0H/T1H from the selected data bit, plus the output register.
- Counters and the FSM stay in the top module.

## Test plan
- **Default 24-bit frame:** PIXELS=2, pixel_data=0xFF0000 then 0x000001 → 48 bits.
  - First 8 bits are high for 5 cycles of 8; the rest high for 2 of 8.
  - The last bit is high for 5.
  - frame_done pulses at cycle 384+400.
- **32-bit mode:**
  - reg_ctrl_32bit=1 → pixel_bit_index_out starts at 31, frame is 2×32×8+400 cycles.
  - Toggling reg_ctrl_32bit mid-frame does not change the length.
- **Init abort:** assert reg_ctrl_init at pixel 1, bit 10 → next cycle state=0, neo_out=0, pixel_addr=0, no frame_done.
- **Async reset:** drop rstn mid-TRANSMIT between edges → outputs 0 immediately. After release, the state stays IDLE until run is asserted.
- **Run drop mid-frame:** drop run at half frame → the frame completes, frame_done pulses once, then IDLE.
- **Loop macro:**
  - With ANTON_NEOPIXEL_LOOP_EN and run held, the frames are back-to-back (TRANSMIT the cycle after frame_done).
  - Without it, IDLE follows and no second frame starts until run toggles.

Source files
------------

// File: rtl/anton_neopixel_stream_seq_pkg.sv
// anton_neopixel_stream_seq_pkg
// Shared definitions for the NeoPixel stream sequencer: the state encoding
// seen on the 'state' port and the first-bit index for 24-bit (GRB) and
// 32-bit (GRBW) pixels.
// No ports (package).
package anton_neopixel_stream_seq_pkg;

  typedef enum logic [1:0] {
    ENUM_STATE_IDLE     = 2'd0,
    ENUM_STATE_TRANSMIT = 2'd1,
    ENUM_STATE_RESET    = 2'd2
  } state_e;

  localparam logic [4:0] BITS24_FIRST = 5'd23;
  localparam logic [4:0] BITS32_FIRST = 5'd31;

  // Bits go out MSB first, so a pixel starts at its highest bit index.
  function automatic logic [4:0] first_bit(input logic mode_32);
    return mode_32 ? BITS32_FIRST : BITS24_FIRST;
  endfunction

endpackage

// File: rtl/anton_neopixel_bit_shaper.sv
// anton_neopixel_bit_shaper
// Turns the current substep and data bit into the NeoPixel waveform: the line
// is high for T1H substeps on a 1 bit and T0H substeps on a 0 bit, and the
// result is registered so the serial line is glitch-free.
// Ports:
//   clk7mhz  - clock
//   rstn     - asynchronous active-low reset
//   clear    - synchronous clear of the output (abort)
//   active   - sequencer is in TRANSMIT
//   substep  - current substep within the bit
//   data_bit - value of the bit being sent
//   neo_out  - registered serial data line
module anton_neopixel_bit_shaper #(
  parameter int SUBSTEPS = 8,
  parameter int T0H      = 2,
  parameter int T1H      = 5,
  localparam int SW      = $clog2(SUBSTEPS)
) (
  input  logic          clk7mhz,
  input  logic          rstn,
  input  logic          clear,
  input  logic          active,
  input  logic [SW-1:0] substep,
  input  logic          data_bit,
  output logic          neo_out
);

  // One extra bit so the thresholds always fit regardless of SUBSTEPS.
  localparam logic [SW:0] T0H_W = (SW+1)'(T0H);
  localparam logic [SW:0] T1H_W = (SW+1)'(T1H);

  logic [SW:0] threshold;
  logic        high_next;

  always_comb begin
    threshold = data_bit ? T1H_W : T0H_W;
    high_next = active && ({1'b0, substep} < threshold);
  end

  always_ff @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) begin
      neo_out <= 1'b0;
    end else begin
      neo_out <= clear ? 1'b0 : high_next;
    end
  end

endmodule

// File: rtl/anton_neopixel_stream_seq.sv
// anton_neopixel_stream_seq
// NeoPixel stream sequencer: IDLE/TRANSMIT/RESET state machine with substep,
// bit and pixel counters, addressing the pixel buffer directly and driving a
// registered serial line. Supports 24-bit (GRB) and 32-bit (GRBW) pixels.
// Optional feature macro: ANTON_NEOPIXEL_LOOP_EN -- when defined, frames
// repeat back-to-back while reg_ctrl_run stays high; otherwise each run
// assertion produces exactly one frame.
// Ports:
//   clk7mhz               - sole clock
//   rstn                  - asynchronous active-low reset
//   reg_ctrl_init         - synchronous abort to IDLE (highest priority)
//   reg_ctrl_run          - enable streaming
//   reg_ctrl_32bit        - 1 = 32 bits/pixel, 0 = 24 bits/pixel
//   pixel_data            - pixel buffer data for pixel_addr
//   pixel_addr            - registered index of the pixel being sent
//   state                 - current state encoding
//   neo_out               - registered serial data line
//   bit_pattern_index_out - current substep
//   pixel_bit_index_out   - current bit (counts down, MSB first)
//   frame_done            - one-cycle pulse in the last RESET cycle
module anton_neopixel_stream_seq
  import anton_neopixel_stream_seq_pkg::*;
#(
  parameter int PIXELS       = 8,
  parameter int SUBSTEPS     = 8,
  parameter int T0H          = 2,
  parameter int T1H          = 5,
  parameter int RESET_CYCLES = 400,
  localparam int AW          = (PIXELS > 1) ? $clog2(PIXELS) : 1,
  localparam int SW          = $clog2(SUBSTEPS)
) (
  input  logic          clk7mhz,
  input  logic          rstn,
  input  logic          reg_ctrl_init,
  input  logic          reg_ctrl_run,
  input  logic          reg_ctrl_32bit,
  input  logic [31:0]   pixel_data,
  output logic [AW-1:0] pixel_addr,
  output logic [1:0]    state,
  output logic          neo_out,
  output logic [SW-1:0] bit_pattern_index_out,
  output logic [4:0]    pixel_bit_index_out,
  output logic          frame_done
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(SUBSTEPS - 1);
  localparam logic [AW-1:0] PIX_LAST = AW'(PIXELS - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);

  state_e        state_q;
  logic [SW-1:0] substep;
  logic [4:0]    bit_idx;
  logic [RW-1:0] reset_cnt;
  logic          mode_32;
  logic          armed;

  assign state                 = state_q;
  assign bit_pattern_index_out = substep;
  assign pixel_bit_index_out   = bit_idx;

  // Sequencer FSM and counters. armed makes the default build one-shot: it is
  // dropped at frame end and only re-armed once run has been seen low. Later
  // assignments to armed inside the case override the re-arm at the top.
  always_ff @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ENUM_STATE_IDLE;
      substep    <= '0;
      bit_idx    <= '0;
      pixel_addr <= '0;
      reset_cnt  <= '0;
      mode_32    <= 1'b0;
      armed      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!reg_ctrl_run) armed <= 1'b1;

      if (reg_ctrl_init) begin
        state_q    <= ENUM_STATE_IDLE;
        substep    <= '0;
        bit_idx    <= '0;
        pixel_addr <= '0;
        reset_cnt  <= '0;
      end else begin
        case (state_q)
          ENUM_STATE_IDLE: begin
            if (reg_ctrl_run && armed) begin
              state_q    <= ENUM_STATE_TRANSMIT;
              mode_32    <= reg_ctrl_32bit;
              bit_idx    <= first_bit(reg_ctrl_32bit);
              substep    <= '0;
              pixel_addr <= '0;
            end
          end

          ENUM_STATE_TRANSMIT: begin
            if (substep == SUB_LAST) begin
              substep <= '0;
              if (bit_idx == 5'd0) begin
                if (pixel_addr == PIX_LAST) begin
                  state_q    <= ENUM_STATE_RESET;
                  reset_cnt  <= '0;
                  pixel_addr <= '0;
                  // A one-cycle gap makes the first RESET cycle also the last.
                  if (RESET_CYCLES == 1) frame_done <= 1'b1;
                end else begin
                  pixel_addr <= pixel_addr + AW'(1);
                  bit_idx    <= first_bit(mode_32);
                end
              end else begin
                bit_idx <= bit_idx - 5'd1;
              end
            end else begin
              substep <= substep + SW'(1);
            end
          end

          ENUM_STATE_RESET: begin
            if (reset_cnt == RST_LAST) begin
              reset_cnt <= '0;
`ifdef ANTON_NEOPIXEL_LOOP_EN
              if (reg_ctrl_run) begin
                state_q    <= ENUM_STATE_TRANSMIT;
                mode_32    <= reg_ctrl_32bit;
                bit_idx    <= first_bit(reg_ctrl_32bit);
                substep    <= '0;
                pixel_addr <= '0;
              end else begin
                state_q <= ENUM_STATE_IDLE;
              end
`else
              state_q <= ENUM_STATE_IDLE;
              if (reg_ctrl_run) armed <= 1'b0;
`endif
            end else begin
              reset_cnt <= reset_cnt + RW'(1);
              // Registered pulse lands in the cycle where the counter is last.
              if (reset_cnt + RW'(1) == RST_LAST) frame_done <= 1'b1;
            end
          end

          default: state_q <= ENUM_STATE_IDLE;
        endcase
      end
    end
  end

  anton_neopixel_bit_shaper #(
    .SUBSTEPS (SUBSTEPS),
    .T0H      (T0H),
    .T1H      (T1H)
  ) u_shaper (
    .clk7mhz  (clk7mhz),
    .rstn     (rstn),
    .clear    (reg_ctrl_init),
    .active   (state_q == ENUM_STATE_TRANSMIT),
    .substep  (substep),
    .data_bit (pixel_data[bit_idx]),
    .neo_out  (neo_out)
  );

endmodule

// File: tb/tb_anton_neopixel_stream_seq.sv
// tb_anton_neopixel_stream_seq
// Directed bench for the NeoPixel stream sequencer with PIXELS=2 and default
// timing. A two-entry array stands in for the pixel buffer.
module tb_anton_neopixel_stream_seq;

  localparam int PIXELS = 2;

  logic        clk7mhz = 1'b0;
  logic        rstn;
  logic        reg_ctrl_init;
  logic        reg_ctrl_run;
  logic        reg_ctrl_32bit;
  logic [31:0] pixel_data;
  logic [0:0]  pixel_addr;
  logic [1:0]  state;
  logic        neo_out;
  logic [2:0]  bit_pattern_index_out;
  logic [4:0]  pixel_bit_index_out;
  logic        frame_done;

  logic [31:0] mem [PIXELS];

  int checks = 0;
  int errors = 0;

  always #5 clk7mhz = ~clk7mhz;

  // Pixel buffer model: combinational read of the addressed pixel.
  assign pixel_data = mem[pixel_addr];

  anton_neopixel_stream_seq #(
    .PIXELS       (PIXELS),
    .SUBSTEPS     (8),
    .T0H          (2),
    .T1H          (5),
    .RESET_CYCLES (400)
  ) dut (
    .clk7mhz               (clk7mhz),
    .rstn                  (rstn),
    .reg_ctrl_init         (reg_ctrl_init),
    .reg_ctrl_run          (reg_ctrl_run),
    .reg_ctrl_32bit        (reg_ctrl_32bit),
    .pixel_data            (pixel_data),
    .pixel_addr            (pixel_addr),
    .state                 (state),
    .neo_out               (neo_out),
    .bit_pattern_index_out (bit_pattern_index_out),
    .pixel_bit_index_out   (pixel_bit_index_out),
    .frame_done            (frame_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk7mhz);
    @(negedge clk7mhz);
  endtask

  // Expected line level for global substep j of a frame with 'bits' per pixel.
  function automatic logic expNeo(input int j, input int bits);
    int k, pix, pos, sub;
    logic b;
    k   = j / 8;
    sub = j % 8;
    pix = k / bits;
    pos = bits - 1 - (k % bits);
    b   = mem[pix][pos];
    return (sub < (b ? 5 : 2));
  endfunction

  // Start a frame from IDLE; returns at the falling edge after the start edge.
  task automatic applyStimulus(input logic m32);
    reg_ctrl_32bit = m32;
    reg_ctrl_run   = 1'b1;
    step();
  endtask

  // Count cycles until frame_done is seen, bounded by 'limit'.
  task automatic waitDone(input int limit, output int cyc);
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < limit) begin
      step();
      cyc++;
    end
  endtask

  // Force the sequencer back to an armed IDLE.
  task automatic cleanup();
    reg_ctrl_run  = 1'b0;
    reg_ctrl_init = 1'b1;
    step();
    reg_ctrl_init = 1'b0;
    step();
  endtask

  initial begin
    int cyc;
    int pulses;

    rstn           = 1'b0;
    reg_ctrl_init  = 1'b0;
    reg_ctrl_run   = 1'b0;
    reg_ctrl_32bit = 1'b0;
    mem[0]         = 32'h00FF_0000;
    mem[1]         = 32'h0000_0001;
    repeat (3) step();
    rstn = 1'b1;
    step();

    // Reset state
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_neo", 32'(neo_out), 32'd0);
    checkOutput("rst_addr", 32'(pixel_addr), 32'd0);
    checkOutput("rst_done", 32'(frame_done), 32'd0);
    checkOutput("rst_bit", 32'(pixel_bit_index_out), 32'd0);

    // Default 24-bit frame, full waveform check
    applyStimulus(1'b0);
    checkOutput("f24_state", 32'(state), 32'd1);
    checkOutput("f24_bit0", 32'(pixel_bit_index_out), 32'd23);
    checkOutput("f24_sub0", 32'(bit_pattern_index_out), 32'd0);
    for (int j = 0; j < 384; j++) begin
      step();
      checkOutput($sformatf("f24_neo_%0d", j), 32'(neo_out), 32'(expNeo(j, 24)));
      if (j == 191) begin
        checkOutput("f24_addr1", 32'(pixel_addr), 32'd1);
        checkOutput("f24_bit_reload", 32'(pixel_bit_index_out), 32'd23);
      end
    end
    checkOutput("f24_reset_state", 32'(state), 32'd2);
    waitDone(3000, cyc);
    checkOutput("f24_done_cycle", 32'(cyc + 384), 32'd783);
    step();
    checkOutput("f24_done_width", 32'(frame_done), 32'd0);
`ifdef ANTON_NEOPIXEL_LOOP_EN
    checkOutput("loop_back_to_back", 32'(state), 32'd1);
`else
    checkOutput("oneshot_idle", 32'(state), 32'd0);
    repeat (5) step();
    checkOutput("oneshot_stays_idle", 32'(state), 32'd0);
`endif
    cleanup();

    // 32-bit mode, mode toggle mid-frame must not change length
    mem[0] = 32'h8000_0000;
    mem[1] = 32'h0000_0001;
    applyStimulus(1'b1);
    checkOutput("f32_bit0", 32'(pixel_bit_index_out), 32'd31);
    step();
    checkOutput("f32_neo_first", 32'(neo_out), 32'd1);
    repeat (99) step();
    reg_ctrl_32bit = 1'b0;
    waitDone(3000, cyc);
    checkOutput("f32_done_cycle", 32'(cyc + 100), 32'd911);
    cleanup();

    // Init abort at pixel 1, bit 10
    mem[0] = 32'h00A5_A5A5;
    mem[1] = 32'h005A_5A5A;
    applyStimulus(1'b0);
    repeat (296) step();
    checkOutput("abort_pre_addr", 32'(pixel_addr), 32'd1);
    checkOutput("abort_pre_bit", 32'(pixel_bit_index_out), 32'd10);
    reg_ctrl_init = 1'b1;
    step();
    checkOutput("abort_state", 32'(state), 32'd0);
    checkOutput("abort_neo", 32'(neo_out), 32'd0);
    checkOutput("abort_addr", 32'(pixel_addr), 32'd0);
    checkOutput("abort_done", 32'(frame_done), 32'd0);
    checkOutput("abort_bit", 32'(pixel_bit_index_out), 32'd0);
    reg_ctrl_init = 1'b0;

    // Async reset mid-TRANSMIT (run still high so a frame restarts)
    step();
    checkOutput("restart_state", 32'(state), 32'd1);
    repeat (20) step();
    @(posedge clk7mhz);
    #2 rstn = 1'b0;
    #1;
    checkOutput("areset_state", 32'(state), 32'd0);
    checkOutput("areset_neo", 32'(neo_out), 32'd0);
    checkOutput("areset_bit", 32'(pixel_bit_index_out), 32'd0);
    checkOutput("areset_sub", 32'(bit_pattern_index_out), 32'd0);
    reg_ctrl_run = 1'b0;
    @(negedge clk7mhz);
    step();
    rstn = 1'b1;
    repeat (3) step();
    checkOutput("areset_idle_hold", 32'(state), 32'd0);

    // Run drop at half frame: frame completes, single pulse, then IDLE
    applyStimulus(1'b0);
    checkOutput("rundrop_start", 32'(state), 32'd1);
    repeat (192) step();
    reg_ctrl_run = 1'b0;
    waitDone(3000, cyc);
    checkOutput("rundrop_done_cycle", 32'(cyc + 192), 32'd783);
    step();
    checkOutput("rundrop_idle", 32'(state), 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (frame_done === 1'b1) pulses++;
    end
    checkOutput("rundrop_no_extra_pulse", 32'(pulses), 32'd0);
    checkOutput("rundrop_still_idle", 32'(state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
